// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // True for the iterative ops (MULT, MULTU, DIV, DIVU); 1xx are moves or reserved.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // True for the two-operand signed ops (MULT, DIV).
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-to-muldiv handshake bundle: request, operands, flush, status and HI/LO.
// Latency: n/a (wires only).
// Backpressure: pipeline must hold off mult/div and MFHI/MFLO while busy is high.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 iterative datapath: shift-add multiply and restoring shift-subtract divide on magnitudes.
// Latency: one step per cycle while step is high; WIDTH steps give a full result.
// Backpressure: none; the controller decides when to load and when to step.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mq
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // Step arithmetic: conditional add of the multiplicand, or trial subtract of the divisor.
  always_comb begin
    add_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opb_q : {WIDTH{1'b0}})};
    rem_shift = {acc_q, mq_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, opb_q};
  end

  // Accumulator/remainder, multiplier/quotient shift register and operand B register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mq_q  <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      mq_q  <= a_mag;
      opb_q <= b_mag;
    end else if (step) begin
      if (is_div) begin
        // A negative trial means the divisor did not fit: keep the shifted remainder.
        if (!trial[WIDTH]) begin
          acc_q <= trial[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= rem_shift[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_q, mq_q} <= {add_sum, mq_q[WIDTH-1:1]};
      end
    end
  end

  assign acc = acc_q;
  assign mq  = mq_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: controller FSM, iteration counter and HI/LO registers.
// Latency: WIDTH+1 cycles from the start edge to done for mult/div; MTHI/MTLO write next edge.
// Backpressure: busy high in RUN/FINISH; start is ignored while busy, abort cancels without writing.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  logic             sign_a_in;
  logic             sign_b_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             go;
  logic             run_step;

  logic [WIDTH-1:0]   dp_acc;
  logic [WIDTH-1:0]   dp_mq;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Request decode: operand magnitudes for signed ops and the load/step strobes.
  always_comb begin
    sign_a_in = is_signed_op(bus.op) & bus.a[WIDTH-1];
    sign_b_in = is_signed_op(bus.op) & bus.b[WIDTH-1];
    a_mag     = sign_a_in ? -bus.a : bus.a;
    b_mag     = sign_b_in ? -bus.b : bus.b;
    go        = (state == ST_IDLE) && bus.start && !bus.abort && is_muldiv(bus.op);
    run_step  = (state == ST_RUN) && !bus.abort;
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (go),
    .step   (run_step),
    .is_div (is_div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (dp_acc),
    .mq     (dp_mq)
  );

  // Sign correction and divide-by-zero override of the raw magnitude result.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -{dp_acc, dp_mq} : {dp_acc, dp_mq};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -dp_mq : dp_mq;
    rem_fix  = sign_a_q ? -dp_acc : dp_acc;
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end else begin
      {res_hi, res_lo} = prod_fix;
    end
  end

  // Controller FSM with counter, latched op context, HI/LO and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_RUN;
            cnt      <= CNT_W'(WIDTH);
            is_div_q <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            b_zero_q <= (bus.b == '0);
            a_q      <= bus.a;
            busy_q   <= 1'b1;
          end else if (bus.start && !bus.abort) begin
            // Moves complete in one edge; reserved codes fall through untouched.
            if (bus.op == OP_MTHI) hi_q <= bus.a;
            if (bus.op == OP_MTLO) lo_q <= bus.a;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!bus.abort) begin
            hi_q       <= res_hi;
            lo_q       <= res_lo;
            done_q     <= 1'b1;
            div_zero_q <= is_div_q & b_zero_q;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency: checks done arrives WIDTH+1 cycles after the start edge.
// Backpressure: exercises start-while-busy, abort in RUN/FINISH and mid-operation reset.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: plain 64-bit / int arithmetic following the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    longint       ps;
    logic [63:0]  pu;
    int           sa;
    int           sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      3'b000: begin
        ps = longint'(sa) * longint'(sb);
        {h, l} = ps;
      end
      3'b001: begin
        pu = {32'b0, a} * {32'b0, b};
        {h, l} = pu;
      end
      3'b010: begin
        if (b == 0) begin
          l = '1; h = a; dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = a; h = '0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          l = '1; h = a; dz = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One mult/div; optionally fires an MTHI request mid-run which must be ignored.
  task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input bit poke);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         edz;
    int           cyc;
    model(op_v, a_v, b_v, eh, el, edz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    check("busy_after_start", bus.busy, 1);
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      if (poke && cyc == 5) begin
        bus.start = 1'b1; bus.op = 3'b100; bus.a = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", bus.done, 1);
    check("latency", cyc, W + 1);
    check("hi", bus.hi, eh);
    check("lo", bus.lo, el);
    check("div_zero", bus.div_zero, edz);
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("div_zero_clear", bus.div_zero, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  // Single-edge request in IDLE: moves, reserved codes, or anything with abort asserted.
  task automatic idle_req(input logic [2:0] op_v, input logic [W-1:0] a_v, input bit with_abort);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = $urandom; bus.abort = with_abort;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    if (!with_abort && op_v == 3'b100) exp_hi = a_v;
    if (!with_abort && op_v == 3'b101) exp_lo = a_v;
    check("idle_req_busy", bus.busy, 0);
    check("idle_req_hi", bus.hi, exp_hi);
    check("idle_req_lo", bus.lo, exp_lo);
    @(negedge clk);
    check("idle_req_busy2", bus.busy, 0);
  endtask

  task automatic abort_op(input logic [2:0] op_v, input int abort_cyc);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_v; bus.a = $urandom; bus.b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < abort_cyc) begin
      @(negedge clk);
      cyc++;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, exp_hi);
    check("abort_lo", bus.lo, exp_lo);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_late_done", seen, 0);
    check("abort_hi_hold", bus.hi, exp_hi);
  endtask

  task automatic reset_mid_op(input int rst_cyc);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = $urandom; bus.b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < rst_cyc) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_div_zero", bus.div_zero, 0);
    check("rst_hi", bus.hi, exp_hi);
    check("rst_lo", bus.lo, exp_lo);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("rst_no_done", seen, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.abort = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_div_zero", bus.div_zero, 0);
    check("reset_hi", bus.hi, exp_hi);
    check("reset_lo", bus.lo, exp_lo);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b011, 32'd7, 32'd0, 1'b0);
    run_op(3'b010, 32'hFFFF_FFF0, 32'd0, 1'b0);

    idle_req(3'b100, 32'h0000_1234, 1'b0);
    idle_req(3'b101, 32'hCAFE_F00D, 1'b0);
    idle_req(3'b110, 32'h5555_5555, 1'b0);
    idle_req(3'b111, 32'hAAAA_AAAA, 1'b0);
    idle_req(3'b100, 32'hDEAD_BEEF, 1'b1);
    idle_req(3'b000, 32'h0000_0003, 1'b1);

    run_op(3'b000, 32'd1234, 32'hFFFF_FF00, 1'b1);

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 3)), pick(), pick(), (i % 7) == 3);
    end

    abort_op(3'b000, 10);
    abort_op(3'b011, 32);

    reset_mid_op(5);

    run_op(3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
